// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// With SERIAL_ADDER_SUB_EN defined, the bundle also carries the sub select.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;

  modport master (output start, a, b, sub, input busy, done, s, c);
  modport slave  (input start, a, b, sub, output busy, done, s, c);
`else
  modport master (output start, a, b, input busy, done, s, c);
  modport slave  (input start, a, b, output busy, done, s, c);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice (two half-adders plus carry flop), LSB first.
// Optional SERIAL_ADDER_SUB_EN adds a sub input that computes a-b (c=1 means no borrow).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, a_sr_next;
  logic [WIDTH-1:0] b_sr_reg, b_sr_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic             cy_reg, cy_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] s_reg, s_next;
  logic             c_reg, c_next;

  logic [WIDTH-1:0] b_load;
  logic             cy_load;
  logic             hs1, hc1, hc2, sum_bit, carry_out;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert b and inject a carry-in of 1.
  assign b_load  = bus.sub ? ~bus.b : bus.b;
  assign cy_load = bus.sub;
`else
  assign b_load  = bus.b;
  assign cy_load = 1'b0;
`endif

  assign hs1       = a_sr_reg[0] ^ b_sr_reg[0];
  assign hc1       = a_sr_reg[0] & b_sr_reg[0];
  assign sum_bit   = hs1 ^ cy_reg;
  assign hc2       = hs1 & cy_reg;
  assign carry_out = hc1 | hc2;

  always_comb begin
    state_next = state_reg;
    a_sr_next  = a_sr_reg;
    b_sr_next  = b_sr_reg;
    res_next   = res_reg;
    cy_next    = cy_reg;
    count_next = count_reg;
    s_next     = s_reg;
    c_next     = c_reg;
    case (state_reg)
      IDLE, DONE: begin
        // DONE accepts start exactly like IDLE so back-to-back ops have no gap.
        if (bus.start) begin
          a_sr_next  = bus.a;
          b_sr_next  = b_load;
          res_next   = '0;
          cy_next    = cy_load;
          count_next = '0;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        a_sr_next  = a_sr_reg >> 1;
        b_sr_next  = b_sr_reg >> 1;
        res_next   = {sum_bit, res_reg[WIDTH-1:1]};
        cy_next    = carry_out;
        count_next = count_reg + CW'(1);
        if (count_reg == LAST) begin
          s_next     = {sum_bit, res_reg[WIDTH-1:1]};
          c_next     = carry_out;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      res_reg   <= '0;
      cy_reg    <= 1'b0;
      count_reg <= '0;
      s_reg     <= '0;
      c_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_sr_reg  <= a_sr_next;
      b_sr_reg  <= b_sr_next;
      res_reg   <= res_next;
      cy_reg    <= cy_next;
      count_reg <= count_next;
      s_reg     <= s_next;
      c_reg     <= c_next;
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign bus.s    = s_reg;
  assign bus.c    = c_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: constant vector table, corner-case sequences
// and randomized operations compared against an arithmetic reference model.
module tb_serial_adder;
  localparam int W = 8;

  logic clk;
  logic rst;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_s;
    logic         exp_c;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = sub;
`else
    if (sub) $display("note: sub requested in an add-only build");
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] exp_s, input logic exp_c, input string tag);
    int n;
    int busy_cnt;
    drive_op(a, b, sub);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    n = 1;
    busy_cnt = 0;
    while (!bus.done && n < 4 * W) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    $display("op %s a=%h b=%h sub=%b -> s=%h c=%b (exp s=%h c=%b) latency=%0d",
             tag, a, b, sub, bus.s, bus.c, exp_s, exp_c, n);
    check({tag, "_latency"}, 64'(n), 64'(W + 1));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({tag, "_s"}, 64'(bus.s), 64'(exp_s));
    check({tag, "_c"}, 64'(bus.c), 64'(exp_c));
    check({tag, "_busy_in_done"}, 64'(bus.busy), 64'(0));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(bus.done), 64'(0));
    check({tag, "_s_hold"}, 64'(bus.s), 64'(exp_s));
    check({tag, "_c_hold"}, 64'(bus.c), 64'(exp_c));
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] ra, rb, ms;
    logic         rsub, mc;
    int           dcnt, bcnt, n;
    logic [W-1:0] got_s;
    logic         got_c;

    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0});
    vecs.push_back('{8'h07, 8'h05, 1'b1, 8'h02, 1'b1});
    vecs.push_back('{8'h42, 8'h42, 1'b1, 8'h00, 1'b1});
`endif

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_s", 64'(bus.s), 64'(0));
    check("reset_c", 64'(bus.c), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp_s, vecs[i].exp_c, $sformatf("vec%0d", i));

    // start re-asserted mid-RUN with different operands must be ignored
    drive_op(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    dcnt = 0; bcnt = 0; got_s = '0; got_c = 1'b0;
    for (int i = 1; i < 3 * W; i++) begin
      if (i == 2) drive_op(8'hFF, 8'hFF, 1'b0);
      if (i == 3) bus.start = 1'b0;
      if (bus.busy) bcnt++;
      if (bus.done) begin
        dcnt++;
        got_s = bus.s;
        got_c = bus.c;
      end
      @(negedge clk);
    end
    $display("op ignore_start a=10 b=20 -> s=%h c=%b dones=%0d busy=%0d", got_s, got_c, dcnt, bcnt);
    check("ignore_done_count", 64'(dcnt), 64'(1));
    check("ignore_busy_cycles", 64'(bcnt), 64'(W));
    check("ignore_s", 64'(got_s), 64'h30);
    check("ignore_c", 64'(got_c), 64'(0));

    // reset in the 4th busy cycle aborts the op and clears the results
    drive_op(8'h3C, 8'h0F, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i < 4; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("op reset_mid_run -> busy=%b done=%b s=%h c=%b", bus.busy, bus.done, bus.s, bus.c);
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_s", 64'(bus.s), 64'(0));
    check("abort_c", 64'(bus.c), 64'(0));
    dcnt = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (bus.done) dcnt++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(dcnt), 64'(0));
    do_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "after_abort");

    // back-to-back: start held through the DONE cycle
    drive_op(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_latency", 64'(n), 64'(W + 1));
    check("b2b_first_s", 64'(bus.s), 64'h46);
    drive_op(8'h80, 8'h80, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_no_gap_busy", 64'(bus.busy), 64'(1));
    check("b2b_no_gap_done", 64'(bus.done), 64'(0));
    check("b2b_first_s_hold", 64'(bus.s), 64'h46);
    n = 1;
    while (!bus.done && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    $display("op back_to_back a=80 b=80 -> s=%h c=%b latency=%0d", bus.s, bus.c, n);
    check("b2b_second_latency", 64'(n), 64'(W + 1));
    check("b2b_second_s", 64'(bus.s), 64'h00);
    check("b2b_second_c", 64'(bus.c), 64'(1));
    @(negedge clk);

    // randomized operations against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rsub = 1'($urandom_range(0, 1));
`else
      rsub = 1'b0;
`endif
      if (rsub) begin
        ms = ra - rb;
        mc = (ra >= rb);
      end else begin
        {mc, ms} = {1'b0, ra} + {1'b0, rb};
      end
      do_op(ra, rb, rsub, ms, mc, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
